// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source numbering for the CDB arbiter.
// Source indices double as grant bit positions.
package cdb_arbiter_pkg;

    localparam int NUM_SRC      = 5;
    localparam int QUEUE_DEPTH  = 4;
    localparam int STARVE_LIMIT = 8;

    typedef enum logic [2:0] {
        SRC_ALU    = 3'd0,
        SRC_MUL    = 3'd1,
        SRC_BR     = 3'd2,
        SRC_DCACHE = 3'd3,
        SRC_SQ     = 3'd4
    } src_e;

endpackage

// File: rtl/cdb_rr_picker.sv
// Rotating priority picker: first requester at or after the
// pointer (wrapping) wins, returned as a one-hot vector.
module cdb_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_pick;
    logic [2*N-1:0] w_back;

    // rotate so the pointer sits at bit 0, take lowest set bit, rotate back
    always_comb begin
        w_dbl   = {i_req, i_req} >> i_rr_ptr;
        w_rot   = w_dbl[N-1:0];
        w_pick  = w_rot & (~w_rot + N'(1));
        w_back  = {w_pick, w_pick} << i_rr_ptr;
        o_grant = w_back[2*N-1:N];
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: tracks per-source result queue counts,
// grants one source per cycle round-robin with a starvation override.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = cdb_arbiter_pkg::NUM_SRC,
    parameter int QUEUE_DEPTH  = cdb_arbiter_pkg::QUEUE_DEPTH,
    parameter int STARVE_LIMIT = cdb_arbiter_pkg::STARVE_LIMIT
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [NUM_SRC-1:0]                       push,
    output logic [NUM_SRC-1:0]                       fu_ready,
    output logic [NUM_SRC-1:0]                       grant,
    output logic                                     grant_valid,
    output logic [NUM_SRC*$clog2(QUEUE_DEPTH+1)-1:0] occupancy,
    output logic                                     overflow_err
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [OCC_W-1:0]   r_occ [NUM_SRC];
    logic [AGE_W-1:0]   r_age [NUM_SRC];
    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_overflow;

    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_rr_grant;
    logic [NUM_SRC-1:0] w_force_grant;
    logic               w_force_any;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_drop;
    logic [PTR_W-1:0]   w_next_ptr;

    // request and space status straight from the tracked counts
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_req[i]   = (r_occ[i] != '0);
            w_ready[i] = (r_occ[i] < OCC_W'(QUEUE_DEPTH));
            w_drop[i]  = push[i] & ~w_ready[i] & ~w_grant[i];
        end
    end

    cdb_rr_picker #(
        .N  (NUM_SRC),
        .PW (PTR_W)
    ) u_picker (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_rr_grant)
    );

    // lowest-index starved source overrides the round-robin pick
    always_comb begin
        w_force_grant = '0;
        w_force_any   = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (r_age[i] == AGE_W'(STARVE_LIMIT)) begin
                w_force_grant    = '0;
                w_force_grant[i] = 1'b1;
                w_force_any      = 1'b1;
            end
        end
        w_grant = w_force_any ? w_force_grant : w_rr_grant;
    end

    // pointer moves just past whoever was granted
    always_comb begin
        w_next_ptr = r_rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_next_ptr = (i == NUM_SRC - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // counts, ages, pointer and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_occ[i] <= '0;
                r_age[i] <= '0;
            end
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_occ[i] <= '0;
                r_age[i] <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_drop[i]) begin
                    r_occ[i] <= r_occ[i] + OCC_W'(push[i])
                              - OCC_W'(w_grant[i]);
                end
                if (w_req[i] && !w_grant[i]) begin
                    if (r_age[i] != AGE_W'(STARVE_LIMIT)) begin
                        r_age[i] <= r_age[i] + AGE_W'(1);
                    end
                end else begin
                    r_age[i] <= '0;
                end
            end
        end
    end

    // drive outputs
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            occupancy[i*OCC_W +: OCC_W] = r_occ[i];
        end
        fu_ready     = w_ready;
        grant        = w_grant;
        grant_valid  = |w_grant;
        overflow_err = r_overflow;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances (default and short starvation
// limit) checked every cycle against a queue-count model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS = 5;
    localparam int QD = 4;
    localparam int OW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [NS-1:0] push  = '0;

    logic [NS-1:0]    fu_ready [2];
    logic [NS-1:0]    grant [2];
    logic             grant_valid [2];
    logic [NS*OW-1:0] occupancy [2];
    logic             overflow_err [2];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    int  m_occ [2][NS];
    int  m_age [2][NS];
    int  m_ptr [2];
    bit  m_ovf [2];
    int  lim [2] = '{8, 2};
    int  tgt [NS] = '{3, 2, 1, 4, 1};

    always #5 clock = ~clock;

    cdb_arbiter u_dut0 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .push         (push),
        .fu_ready     (fu_ready[0]),
        .grant        (grant[0]),
        .grant_valid  (grant_valid[0]),
        .occupancy    (occupancy[0]),
        .overflow_err (overflow_err[0])
    );

    cdb_arbiter #(.STARVE_LIMIT(2)) u_dut1 (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .push         (push),
        .fu_ready     (fu_ready[1]),
        .grant        (grant[1]),
        .grant_valid  (grant_valid[1]),
        .occupancy    (occupancy[1]),
        .overflow_err (overflow_err[1])
    );

    function automatic int mgrant(int d);
        for (int i = 0; i < NS; i++)
            if (m_age[d][i] == lim[d]) return i;
        for (int k = 0; k < NS; k++) begin
            int idx;
            idx = (m_ptr[d] + k) % NS;
            if (m_occ[d][idx] != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (reset || flush) begin
                for (int i = 0; i < NS; i++) begin
                    m_occ[d][i] = 0;
                    m_age[d][i] = 0;
                end
                m_ptr[d] = 0;
                if (reset) m_ovf[d] = 1'b0;
            end else begin
                int g;
                g = mgrant(d);
                for (int i = 0; i < NS; i++) begin
                    bit gi, rq;
                    gi = (g == i);
                    rq = (m_occ[d][i] != 0);
                    if (push[i] && m_occ[d][i] == QD && !gi)
                        m_ovf[d] = 1'b1;
                    else
                        m_occ[d][i] = m_occ[d][i] + int'(push[i]) - int'(gi);
                    if (rq && !gi)
                        m_age[d][i] = (m_age[d][i] + 1 > lim[d]) ? lim[d] : m_age[d][i] + 1;
                    else
                        m_age[d][i] = 0;
                end
                if (g >= 0) m_ptr[d] = (g + 1) % NS;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [NS-1:0] eg, er;
            g  = mgrant(d);
            eg = '0;
            er = '0;
            if (g >= 0) eg[g] = 1'b1;
            for (int i = 0; i < NS; i++) begin
                er[i] = (m_occ[d][i] < QD);
                chk($sformatf("d%0d occ[%0d]", d, i),
                    32'(occupancy[d][i*OW +: OW]), 32'(m_occ[d][i]));
            end
            chk($sformatf("d%0d grant", d), 32'(grant[d]), 32'(eg));
            chk($sformatf("d%0d grant_valid", d), 32'(grant_valid[d]), 32'(g >= 0));
            chk($sformatf("d%0d fu_ready", d), 32'(fu_ready[d]), 32'(er));
            chk($sformatf("d%0d overflow", d), 32'(overflow_err[d]), 32'(m_ovf[d]));
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (chk_en) compare_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        chk("reset grant", 32'(grant[0]), 32'h0);
        chk("reset grant_valid", 32'(grant_valid[0]), 32'h0);
        chk("reset fu_ready", 32'(fu_ready[0]), 32'h1f);
        chk("reset occupancy", 32'(occupancy[0]), 32'h0);
        chk("reset overflow", 32'(overflow_err[0]), 32'h0);

        push = 5'b10001;
        tick();
        push = '0;
        chk("alu+sq first", 32'(grant[0]), 32'h01);
        tick();
        chk("alu+sq second", 32'(grant[0]), 32'h10);
        tick();
        chk("alu+sq idle", 32'(grant_valid[0]), 32'h0);
        chk("alu+sq drained", 32'(occupancy[0]), 32'h0);

        for (int c = 0; c < 24; c++) begin
            int g;
            g = mgrant(0);
            for (int i = 0; i < NS; i++)
                push[i] = (m_occ[0][i] < QD) || (g == i);
            tick();
        end
        chk("full granted push occ", 32'(occupancy[0]), 32'(15'o44444));
        chk("full granted push ovf", 32'(overflow_err[0]), 32'h0);
        chk("full fu_ready", 32'(fu_ready[0]), 32'h0);

        push = 5'h1f;
        repeat (3) tick();
        chk("overflow set", 32'(overflow_err[0]), 32'h1);
        chk("mul not ready", 32'(fu_ready[0][SRC_MUL]), 32'h0);
        chk("mul occ held", 32'(occupancy[0][int'(SRC_MUL)*OW +: OW]), 32'd4);

        push  = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 24; c++) begin
            int g;
            g = mgrant(0);
            for (int i = 0; i < NS; i++)
                push[i] = (m_occ[0][i] - int'(g == i)) < tgt[i];
            tick();
        end
        chk("pre-flush occ", 32'(occupancy[0]), 32'(15'o14123));
        flush = 1'b1;
        push  = 5'h1f;
        tick();
        flush = 1'b0;
        push  = '0;
        chk("flush occ d0", 32'(occupancy[0]), 32'h0);
        chk("flush occ d1", 32'(occupancy[1]), 32'h0);
        chk("flush fu_ready", 32'(fu_ready[0]), 32'h1f);
        chk("flush grant", 32'(grant[0]), 32'h0);

        push = 5'h1f;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rotate %0d", k), 32'(grant[0]), 32'(1 << (k % NS)));
            tick();
        end

        push  = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push  = 5'h0f;
        tick();
        chk("starve c1 d1", 32'(grant[1]), 32'h1);
        tick();
        chk("starve c2 d1", 32'(grant[1]), 32'h2);
        tick();
        chk("starve c3 d1", 32'(grant[1]), 32'h4);
        tick();
        chk("starve c4 d1", 32'(grant[1]), 32'h1);
        chk("starve c4 d0", 32'(grant[0]), 32'h8);

        for (int c = 0; c < 600; c++) begin
            reset = ($urandom % 150 == 0);
            flush = ($urandom % 40 == 0);
            for (int i = 0; i < NS; i++)
                push[i] = ($urandom % 3 == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        push  = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
